// File: rtl/conv_layer_sched.sv
// Sequencer for the convolution layer: admits NUM_PROD products into the register file, then issues grouped 3-port reads.
// Optional cycle/stall counters are compiled in with `define CONV_SCHED_PERF_EN.
module conv_layer_sched #(
   parameter int ADDR_W   = 4,
   parameter int NUM_PROD = 15,
   parameter int GROUP    = 3,
   parameter int ADD_LAT  = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr1,
   output logic [ADDR_W-1:0] o_rd_addr2,
   output logic [ADDR_W-1:0] o_rd_addr3,
   output logic              o_res_valid,
   output logic              o_busy,
   output logic              o_done
`ifdef CONV_SCHED_PERF_EN
   ,
   output logic [15:0]       o_perf_cycles,
   output logic [7:0]        o_perf_stalls
`endif
);

   localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(NUM_PROD - 1);
   localparam logic [ADDR_W-1:0] LAST_G = ADDR_W'(NUM_PROD / GROUP - 1);
   localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(GROUP);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_in_ready;
   logic [ADDR_W-1:0]   r_wcnt;
   logic [ADDR_W-1:0]   r_gcnt;
   logic                r_rd_en;
   logic [ADDR_W-1:0]   r_rd_addr1;
   logic [ADDR_W-1:0]   r_rd_addr2;
   logic [ADDR_W-1:0]   r_rd_addr3;
   logic [ADDR_W-1:0]   r_pipe_unused_guard;
   logic [ADD_LAT-1:0]  r_pipe;
   logic                r_busy;
   logic                r_done;
   logic                w_wr_en;
   logic                w_pipe_tail_empty;

   // Write strobe follows the handshake directly so a stalled cycle never writes.
   always_comb begin
      w_wr_en           = i_in_valid & r_in_ready;
      w_pipe_tail_empty = ((r_pipe << 1) == '0);
   end

   // Phase sequencer; r_pipe carries each read issue forward to its adder result.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state             <= ST_IDLE;
         r_in_ready          <= 1'b0;
         r_wcnt              <= '0;
         r_gcnt              <= '0;
         r_rd_en             <= 1'b0;
         r_rd_addr1          <= '0;
         r_rd_addr2          <= '0;
         r_rd_addr3          <= '0;
         r_pipe_unused_guard <= '0;
         r_pipe              <= '0;
         r_busy              <= 1'b0;
         r_done              <= 1'b0;
      end else begin
         r_pipe <= (r_pipe << 1) | ADD_LAT'(r_rd_en);
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state    <= ST_LOAD;
                  r_busy     <= 1'b1;
                  r_in_ready <= 1'b1;
                  r_wcnt     <= '0;
               end
            end
            ST_LOAD: begin
               if (w_wr_en) begin
                  if (r_wcnt == LAST_W) begin
                     r_state    <= ST_READ;
                     r_in_ready <= 1'b0;
                     r_rd_en    <= 1'b1;
                     r_gcnt     <= '0;
                     r_rd_addr1 <= ADDR_W'(0);
                     r_rd_addr2 <= ADDR_W'(1);
                     r_rd_addr3 <= ADDR_W'(2);
                  end else begin
                     r_wcnt <= r_wcnt + ADDR_W'(1);
                  end
               end
            end
            ST_READ: begin
               if (r_gcnt == LAST_G) begin
                  r_state    <= ST_DRAIN;
                  r_rd_en    <= 1'b0;
                  r_rd_addr1 <= '0;
                  r_rd_addr2 <= '0;
                  r_rd_addr3 <= '0;
               end else begin
                  r_gcnt     <= r_gcnt + ADDR_W'(1);
                  r_rd_addr1 <= r_rd_addr1 + STEP;
                  r_rd_addr2 <= r_rd_addr2 + STEP;
                  r_rd_addr3 <= r_rd_addr3 + STEP;
               end
            end
            // Leave once only the oldest pipeline stage can still hold a result.
            ST_DRAIN: begin
               if (w_pipe_tail_empty) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_in_ready <= 1'b0;
               r_rd_en    <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

`ifdef CONV_SCHED_PERF_EN
   logic [15:0] r_perf_cycles;
   logic [7:0]  r_perf_stalls;

   // Saturating pass statistics, restarted by each accepted start.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_perf_cycles <= 16'h0000;
         r_perf_stalls <= 8'h00;
      end else if ((r_state == ST_IDLE) && i_start) begin
         r_perf_cycles <= 16'h0000;
         r_perf_stalls <= 8'h00;
      end else begin
         if (r_busy && (r_perf_cycles != 16'hFFFF)) begin
            r_perf_cycles <= r_perf_cycles + 16'h0001;
         end
         if ((r_state == ST_LOAD) && !i_in_valid && (r_perf_stalls != 8'hFF)) begin
            r_perf_stalls <= r_perf_stalls + 8'h01;
         end
      end
   end

   assign o_perf_cycles = r_perf_cycles;
   assign o_perf_stalls = r_perf_stalls;
`endif

   assign o_in_ready  = r_in_ready;
   assign o_wr_en     = w_wr_en;
   assign o_wr_addr   = r_wcnt;
   assign o_rd_en     = r_rd_en;
   assign o_rd_addr1  = r_rd_addr1;
   assign o_rd_addr2  = r_rd_addr2;
   assign o_rd_addr3  = r_rd_addr3;
   assign o_res_valid = r_pipe[ADD_LAT-1];
   assign o_busy      = r_busy;
   assign o_done      = r_done;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Self-checking bench for conv_layer_sched: an ADD_LAT=1 and an ADD_LAT=3 instance share stimulus
// and are compared cycle by cycle against a trace model built from the pass timing rules.
module tb_conv_layer_sched;

   localparam int MAXC = 256;
   localparam int NP   = 15;
   localparam int NG   = 5;
   localparam logic [21:0] NONADDR = 22'h308007;
   localparam logic [21:0] ALL     = 22'h3FFFFF;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   logic i_start = 1'b0;
   logic i_in_valid = 1'b0;

   logic       in_ready1, wr_en1, rd_en1, res_valid1, busy1, done1;
   logic [3:0] wr_addr1, a1_1, a2_1, a3_1;
   logic       in_ready3, wr_en3, rd_en3, res_valid3, busy3, done3;
   logic [3:0] wr_addr3, a1_3, a2_3, a3_3;
`ifdef CONV_SCHED_PERF_EN
   logic [15:0] perf_cyc1, perf_cyc3;
   logic [7:0]  perf_stl1, perf_stl3;
`endif

   always #5 i_clk = ~i_clk;

   conv_layer_sched #(.ADDR_W(4), .NUM_PROD(15), .GROUP(3), .ADD_LAT(1)) u_dut1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_in_valid(i_in_valid),
      .o_in_ready(in_ready1), .o_wr_en(wr_en1), .o_wr_addr(wr_addr1), .o_rd_en(rd_en1),
      .o_rd_addr1(a1_1), .o_rd_addr2(a2_1), .o_rd_addr3(a3_1),
      .o_res_valid(res_valid1), .o_busy(busy1), .o_done(done1)
`ifdef CONV_SCHED_PERF_EN
      , .o_perf_cycles(perf_cyc1), .o_perf_stalls(perf_stl1)
`endif
   );

   conv_layer_sched #(.ADDR_W(4), .NUM_PROD(15), .GROUP(3), .ADD_LAT(3)) u_dut3 (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_in_valid(i_in_valid),
      .o_in_ready(in_ready3), .o_wr_en(wr_en3), .o_wr_addr(wr_addr3), .o_rd_en(rd_en3),
      .o_rd_addr1(a1_3), .o_rd_addr2(a2_3), .o_rd_addr3(a3_3),
      .o_res_valid(res_valid3), .o_busy(busy3), .o_done(done3)
`ifdef CONV_SCHED_PERF_EN
      , .o_perf_cycles(perf_cyc3), .o_perf_stalls(perf_stl3)
`endif
   );

   wire logic [21:0] w_v1 = {in_ready1, wr_en1, wr_addr1, rd_en1, a1_1, a2_1, a3_1, res_valid1, busy1, done1};
   wire logic [21:0] w_v3 = {in_ready3, wr_en3, wr_addr3, rd_en3, a1_3, a2_3, a3_3, res_valid3, busy3, done3};

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic        st [MAXC];
   logic        iv [MAXC];
   logic [21:0] e_v [2][MAXC];
   logic [21:0] e_m [2][MAXC];

   typedef struct {
      logic [31:0] stall_mask;
      int          start_a;
      int          start_b;
      int          exp_done;
   } vec_t;
   vec_t tab [4];

   task automatic check_vec(input string name, input int cyc, input logic [21:0] got,
                            input logic [21:0] exp, input logic [21:0] msk);
      n_chk++;
      if (((got ^ exp) & msk) != 22'h0) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h (mask %h)", name, cyc, got, exp, msk);
      end else begin
         n_pass++;
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic clear_stim();
      for (int c = 0; c < MAXC; c++) begin
         st[c] = 1'b0;
         iv[c] = 1'b1;
      end
   endtask

   // Expected trace for a pass whose start is accepted in cycle 0.
   // Vector layout: in_ready, wr_en, wr_addr[4], rd_en, a1[4], a2[4], a3[4], res_valid, busy, done.
   task automatic model(input int sel, input int lat, output int d, output int cl);
      int n;
      int c;
      for (int i = 0; i < MAXC; i++) begin
         e_v[sel][i] = 22'h0;
         e_m[sel][i] = NONADDR;
      end
      n  = 0;
      c  = 1;
      cl = -1;
      while (cl < 0 && c < MAXC - 16) begin
         e_v[sel][c][21]    = 1'b1;
         e_v[sel][c][1]     = 1'b1;
         e_v[sel][c][19:16] = 4'(n);
         e_m[sel][c][19:16] = 4'hF;
         if (iv[c]) begin
            e_v[sel][c][20] = 1'b1;
            if (n == NP - 1) cl = c;
            else n++;
         end
         c++;
      end
      if (cl < 0) cl = MAXC - 16;
      for (int k = 0; k < NG; k++) begin
         c = cl + 1 + k;
         e_v[sel][c][15]    = 1'b1;
         e_v[sel][c][1]     = 1'b1;
         e_v[sel][c][14:11] = 4'(3 * k);
         e_v[sel][c][10:7]  = 4'(3 * k + 1);
         e_v[sel][c][6:3]   = 4'(3 * k + 2);
         e_m[sel][c][14:3]  = 12'hFFF;
         e_v[sel][c + lat][2] = 1'b1;
      end
      for (int j = 1; j <= lat; j++) e_v[sel][cl + NG + j][1] = 1'b1;
      d = cl + NG + lat + 1;
      e_v[sel][d][1] = 1'b1;
      e_v[sel][d][0] = 1'b1;
   endtask

   task automatic run_window(input int ncyc, input bit chk3, output int dc1, output int dc3);
      dc1 = -1;
      dc3 = -1;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge i_clk);
         #1;
         i_start    = st[c];
         i_in_valid = iv[c];
         @(negedge i_clk);
         check_vec("lat1", c, w_v1, e_v[0][c], e_m[0][c]);
         if (chk3) check_vec("lat3", c, w_v3, e_v[1][c], e_m[1][c]);
         if (done1 && dc1 < 0) dc1 = c;
         if (done3 && dc3 < 0) dc3 = c;
      end
   endtask

   initial begin
      int d1, d3, cl1, cl3, dc1, dc3;

      tab[0] = '{32'h0000_0000, -1, -1, 22};
      tab[1] = '{32'h0000_0088, -1, -1, 24};
      tab[2] = '{32'h0000_0000,  5, 17, 22};
      tab[3] = '{32'h0001_8002, -1, -1, 25};

      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check_vec("reset1", 0, w_v1, 22'h0, ALL);
      check_vec("reset3", 0, w_v3, 22'h0, ALL);
`ifdef CONV_SCHED_PERF_EN
      chk_int("reset_perf", int'(perf_cyc1) + int'(perf_stl1), 0);
`endif
      i_rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         clear_stim();
         st[0] = 1'b1;
         for (int b = 1; b < 32; b++) if (tab[i].stall_mask[b]) iv[b] = 1'b0;
         if (tab[i].start_a >= 0) st[tab[i].start_a] = 1'b1;
         if (tab[i].start_b >= 0) st[tab[i].start_b] = 1'b1;
         model(0, 1, d1, cl1);
         model(1, 3, d3, cl3);
         run_window(d3 + 3, 1'b1, dc1, dc3);
         chk_int("done_cycle_lat1", dc1, tab[i].exp_done);
         chk_int("done_cycle_lat3", dc3, tab[i].exp_done + 2);
`ifdef CONV_SCHED_PERF_EN
         chk_int("perf_cycles", int'(perf_cyc1), tab[i].exp_done);
         chk_int("perf_stalls", int'(perf_stl1), cl1 - NP);
`endif
      end

      // Asynchronous reset in the middle of the read phase, then a fresh pass.
      clear_stim();
      st[0] = 1'b1;
      model(0, 1, d1, cl1);
      run_window(19, 1'b0, dc1, dc3);
      #2;
      i_rst = 1'b1;
      #1;
      check_vec("async_rst1", 18, w_v1, 22'h0, ALL);
      check_vec("async_rst3", 18, w_v3, 22'h0, ALL);
      @(posedge i_clk);
      #1;
      i_rst   = 1'b0;
      i_start = 1'b0;
      chk_int("no_done_before_rst", dc1, -1);
      model(0, 1, d1, cl1);
      run_window(d1 + 3, 1'b0, dc1, dc3);
      chk_int("done_after_rst", dc1, 22);

      // Back-to-back passes: second start in the cycle after done.
      clear_stim();
      st[0] = 1'b1;
      model(0, 1, d1, cl1);
      run_window(d1 + 1, 1'b0, dc1, dc3);
      chk_int("b2b_first_done", dc1, 22);
      run_window(d1 + 3, 1'b0, dc1, dc3);
      chk_int("b2b_second_done", dc1, 22);

      // Random in_valid patterns with spurious starts during the pass.
      for (int r = 0; r < 8; r++) begin
         clear_stim();
         st[0] = 1'b1;
         for (int c = 1; c < MAXC; c++) iv[c] = ($urandom_range(0, 3) != 0);
         st[$urandom_range(1, 15)] = 1'b1;
         st[$urandom_range(1, 15)] = 1'b1;
         model(0, 1, d1, cl1);
         run_window(d1 + 3, 1'b0, dc1, dc3);
         chk_int("rand_done", dc1, d1);
`ifdef CONV_SCHED_PERF_EN
         chk_int("rand_perf_stalls", int'(perf_stl1), cl1 - NP);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
Sequencing controller for the single-layer convolution datapath (multiplier -> 15-entry product register file -> 3-input adder -> ReLU). It accepts a start pulse and then runs two phases. In the LOAD phase it admits NUM_PROD image/filter pairs through a valid/ready handshake and generates register-file write strobes and addresses. In the READ phase it issues grouped 3-port reads and flags each adder result as valid. It replaces the free-running address counter and owns all write-enable, read-enable and address generation for the layer.

Parameters:
ADDR_W, 4, register-file address width
NUM_PROD, 15, products per layer pass; must be a multiple of GROUP and <= 2**ADDR_W
GROUP, 3, read ports used per read cycle; fixed at 3
ADD_LAT, 1, adder latency in cycles from read issue to valid sum (1..3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle request to begin a pass; accepted only in IDLE
in_valid  in  1  upstream image/filter pair is present
in_ready  out  1  controller accepts a pair this cycle
wr_en  out  1  register-file write enable (drives WriteEn)
wr_addr  out  ADDR_W  register-file write address
rd_en  out  1  register-file read enable
rd_addr1  out  ADDR_W  read port 1 address
rd_addr2  out  ADDR_W  read port 2 address
rd_addr3  out  ADDR_W  read port 3 address
res_valid  out  1  the adder/ReLU output is valid this cycle
busy  out  1  high from start acceptance through DONE
done  out  1  single-cycle pulse when the pass is complete

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; counters 0. Reset mid-pass abandons the pass with no done pulse.
- FSM states: IDLE -> LOAD -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: busy=0, in_ready=0. If start=1, go to LOAD next cycle and set busy=1. A start asserted in any other state is ignored.
- LOAD:
  - in_ready=1 (registered; high for the whole state).
  - wr_en is combinational: wr_en = in_valid & in_ready. wr_addr = wcnt.
  - Each accepted pair increments wcnt. in_valid low stalls with no write and no address advance.
  - After the pair with wcnt==NUM_PROD-1 is accepted, go to READ next cycle and clear in_ready in that same cycle.
- READ:
  - rd_en=1 for exactly NUM_PROD/GROUP consecutive cycles. No stalls.
  - Group k drives rd_addr1=3k, rd_addr2=3k+1, rd_addr3=3k+2, with k=0..NUM_PROD/GROUP-1.
  - After the last group, go to DRAIN.
- res_valid is rd_en delayed by ADD_LAT cycles through a shift register. It pulses once per group, in group order.
- DRAIN: wait until the res_valid pipeline is empty, then go to DONE.
- DONE: done=1 for one cycle, busy stays 1, then IDLE. busy drops in the cycle after done.
- Counters saturate at their terminal values and do not wrap past NUM_PROD-1. Addresses never exceed NUM_PROD-1.
- wr_en and rd_en are never high in the same cycle.
- Defaults (NUM_PROD=15, GROUP=3, ADD_LAT=1), minimum latency from start to done:
  - 1 IDLE->LOAD cycle
  - 15 LOAD cycles
  - 5 READ cycles
  - 1 DRAIN cycle
  - 1 DONE cycle
  - Total: 23 cycles.

Optional Feature:
- Macro CONV_SCHED_PERF_EN.
- Defined: adds output perf_cycles[15:0].
  - Cleared when start is accepted.
  - Increments every cycle while busy=1, saturating at 16'hFFFF.
  - Holds its value after done until the next accepted start. Reset clears it.
  - Also adds output perf_stalls[7:0], counting LOAD cycles with in_valid=0 (saturating).
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Reset, then start=1 for one cycle, with in_valid held 1 -> wr_en high 15 consecutive cycles with wr_addr 0..14. Then rd_en high 5 cycles with triples (0,1,2)...(12,13,14). res_valid pulses 5 times, each 1 cycle after its rd_en. done pulses 23 cycles after start.
- Same as the first scenario, but in_valid=0 on LOAD cycles 3 and 7 -> no writes in those cycles, wr_addr holds its value, and done is delayed by exactly 2 cycles. With PERF_EN: perf_stalls=2, perf_cycles=24.
- start pulsed again at LOAD cycle 5 and during READ -> ignored: addresses continue unchanged and exactly one done pulse occurs.
- rst asserted asynchronously mid-READ (after group 2) -> all outputs 0 immediately, state IDLE, no done. A new start then runs a full, correct pass from wr_addr 0.
- ADD_LAT=3 build -> res_valid pulses lag rd_en by 3 cycles, DRAIN lasts 3 cycles, and done is 25 cycles after start.
- Back-to-back passes: start asserted in the cycle after done -> the second pass begins cleanly with wr_addr 0 and matches the first pass's timing.
